// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq : sequential EX-stage ALU.
//
// Single-cycle logic/arith/compare/shift operations, plus iterative unsigned
// multiply (shift-add) and restoring divide, one bit per clock, behind a
// start/busy/done handshake. All results and flags are registered.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   start        operation request, sampled only while not busy
//   ALUopcode    operation select
//   rega, regb   operands, sampled together with start
//   busy         multi-cycle operation in progress
//   done         one-cycle pulse: result/flags valid
//   result       primary result (MUL low half, DIV quotient)
//   result_hi    MUL high half / DIV remainder, 0 otherwise
//   zero         result == 0
//   sign         result MSB
//   overflow     signed overflow on ADD/SUB
//   div_by_zero  DIVU issued with regb == 0
//
// WIDTH must be a power of two and at least 4.
// ---------------------------------------------------------------------------
module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       ALUopcode,
   input  logic [WIDTH-1:0] rega,
   input  logic [WIDTH-1:0] regb,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             sign,
   output logic             overflow,
   output logic             div_by_zero
);

   localparam int SHW = $clog2(WIDTH);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_SLTU = 4'b0100;
   localparam logic [3:0] OP_SLT  = 4'b0101;
   localparam logic [3:0] OP_XOR  = 4'b0110;
   localparam logic [3:0] OP_NOR  = 4'b0111;
   localparam logic [3:0] OP_SLL  = 4'b1000;
   localparam logic [3:0] OP_SRL  = 4'b1001;
   localparam logic [3:0] OP_SRA  = 4'b1010;
   localparam logic [3:0] OP_MULU = 4'b1011;
   localparam logic [3:0] OP_DIVU = 4'b1100;

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_t;

   state_t           r_state;
   logic [SHW-1:0]   r_cnt;
   logic             r_is_div;
   logic [WIDTH-1:0] r_hi;     // MUL partial product high / DIV partial remainder
   logic [WIDTH-1:0] r_lo;     // MUL multiplier+product low / DIV dividend+quotient
   logic [WIDTH-1:0] r_b;      // latched multiplicand / divisor

   // ------------------------------------------------------------------
   // Single-cycle datapath
   // ------------------------------------------------------------------
   logic [SHW-1:0]   w_shamt;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_alu_res;
   logic             w_alu_ovf;

   assign w_shamt = regb[SHW-1:0];
   assign w_sum   = rega + regb;
   assign w_diff  = rega - regb;

   always_comb begin
      w_alu_res = '0;
      w_alu_ovf = 1'b0;
      case (ALUopcode)
         OP_ADD: begin
            w_alu_res = w_sum;
            // like-signed operands producing an opposite-signed sum
            w_alu_ovf = (rega[WIDTH-1] == regb[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != rega[WIDTH-1]);
         end
         OP_SUB: begin
            w_alu_res = w_diff;
            // A - B overflows only when A and B differ in sign
            w_alu_ovf = (rega[WIDTH-1] != regb[WIDTH-1]) &&
                        (w_diff[WIDTH-1] != rega[WIDTH-1]);
         end
         OP_AND:  w_alu_res = rega & regb;
         OP_OR:   w_alu_res = rega | regb;
         OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (rega < regb)};
         OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(rega) < $signed(regb))};
         OP_XOR:  w_alu_res = rega ^ regb;
         OP_NOR:  w_alu_res = ~(rega | regb);
         OP_SLL:  w_alu_res = rega << w_shamt;
         OP_SRL:  w_alu_res = rega >> w_shamt;
         OP_SRA:  w_alu_res = $unsigned($signed(rega) >>> w_shamt);
         default: w_alu_res = '0;
      endcase
   end

   // ------------------------------------------------------------------
   // Iteration step shared by MULU and DIVU.
   // The first iteration runs on the acceptance edge straight from the
   // operand ports, so the WIDTH iterations finish one edge earlier and
   // busy drops exactly in the cycle done is raised.
   // ------------------------------------------------------------------
   logic             w_from_ports;
   logic [WIDTH-1:0] w_it_hi;
   logic [WIDTH-1:0] w_it_lo;
   logic [WIDTH-1:0] w_it_b;
   logic             w_it_div;

   assign w_from_ports = (r_state == S_IDLE);
   assign w_it_hi  = w_from_ports ? '0 : r_hi;
   assign w_it_lo  = w_from_ports ? rega : r_lo;
   assign w_it_b   = w_from_ports ? regb : r_b;
   assign w_it_div = w_from_ports ? (ALUopcode == OP_DIVU) : r_is_div;

   // shift-add: add multiplicand on LSB of multiplier, shift {carry,hi,lo} right
   logic [WIDTH:0]   w_mul_sum;
   logic [WIDTH-1:0] w_mul_hi;
   logic [WIDTH-1:0] w_mul_lo;

   assign w_mul_sum = {1'b0, w_it_hi} + (w_it_lo[0] ? {1'b0, w_it_b} : {(WIDTH+1){1'b0}});
   assign w_mul_hi  = w_mul_sum[WIDTH:1];
   assign w_mul_lo  = {w_mul_sum[0], w_it_lo[WIDTH-1:1]};

   // restoring divide: shift next dividend bit into remainder, trial subtract
   logic [WIDTH:0]   w_div_shift;
   logic [WIDTH+1:0] w_div_trial;
   logic             w_div_ok;
   logic [WIDTH-1:0] w_div_hi;
   logic [WIDTH-1:0] w_div_lo;

   assign w_div_shift = {w_it_hi, w_it_lo[WIDTH-1]};
   assign w_div_trial = {1'b0, w_div_shift} - {2'b00, w_it_b};
   assign w_div_ok    = ~w_div_trial[WIDTH+1];
   assign w_div_hi    = w_div_ok ? w_div_trial[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
   assign w_div_lo    = {w_it_lo[WIDTH-2:0], w_div_ok};

   logic [WIDTH-1:0] w_nx_hi;
   logic [WIDTH-1:0] w_nx_lo;

   assign w_nx_hi = w_it_div ? w_div_hi : w_mul_hi;
   assign w_nx_lo = w_it_div ? w_div_lo : w_mul_lo;

   logic w_iterative;
   assign w_iterative = (ALUopcode == OP_MULU) ||
                        ((ALUopcode == OP_DIVU) && (regb != '0));

   // ------------------------------------------------------------------
   // Control FSM and registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_is_div    <= 1'b0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_b         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         result      <= '0;
         result_hi   <= '0;
         zero        <= 1'b0;
         sign        <= 1'b0;
         overflow    <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (w_iterative) begin
                     r_hi     <= w_nx_hi;
                     r_lo     <= w_nx_lo;
                     r_b      <= regb;
                     r_is_div <= (ALUopcode == OP_DIVU);
                     r_cnt    <= SHW'(WIDTH - 1);
                     r_state  <= S_RUN;
                     busy     <= 1'b1;
                  end else if (ALUopcode == OP_DIVU) begin
                     // divide by zero short-circuits without iterating
                     result      <= '1;
                     result_hi   <= rega;
                     zero        <= 1'b0;
                     sign        <= 1'b1;
                     overflow    <= 1'b0;
                     div_by_zero <= 1'b1;
                     done        <= 1'b1;
                  end else begin
                     result      <= w_alu_res;
                     result_hi   <= '0;
                     zero        <= (w_alu_res == '0);
                     sign        <= w_alu_res[WIDTH-1];
                     overflow    <= w_alu_ovf;
                     div_by_zero <= 1'b0;
                     done        <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               // start is deliberately not looked at here
               r_hi  <= w_nx_hi;
               r_lo  <= w_nx_lo;
               r_cnt <= r_cnt - 1'b1;
               // this iteration brings the counter to 0: it is the last one
               if (r_cnt == SHW'(1)) begin
                  r_state     <= S_IDLE;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  result      <= w_nx_lo;
                  result_hi   <= w_nx_hi;
                  zero        <= (w_nx_lo == '0);
                  sign        <= w_nx_lo[WIDTH-1];
                  overflow    <= 1'b0;
                  div_by_zero <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq : directed self-checking bench for alu_seq (WIDTH=32 and 8).
// ---------------------------------------------------------------------------
module tb_alu_seq;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_SLTU = 4'b0100;
   localparam logic [3:0] OP_SLT  = 4'b0101;
   localparam logic [3:0] OP_XOR  = 4'b0110;
   localparam logic [3:0] OP_NOR  = 4'b0111;
   localparam logic [3:0] OP_SLL  = 4'b1000;
   localparam logic [3:0] OP_SRL  = 4'b1001;
   localparam logic [3:0] OP_SRA  = 4'b1010;
   localparam logic [3:0] OP_MULU = 4'b1011;
   localparam logic [3:0] OP_DIVU = 4'b1100;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   // WIDTH=32 instance
   logic        s32;
   logic [3:0]  op32;
   logic [31:0] a32, b32;
   logic        busy32, done32, z32, sg32, ov32, dz32;
   logic [31:0] res32, hi32;

   // WIDTH=8 instance
   logic        s8;
   logic [3:0]  op8;
   logic [7:0]  a8, b8;
   logic        busy8, done8, z8, sg8, ov8, dz8;
   logic [7:0]  res8, hi8;

   alu_seq #(.WIDTH(32)) u_dut32 (
      .clk(clk), .reset(reset), .start(s32), .ALUopcode(op32),
      .rega(a32), .regb(b32), .busy(busy32), .done(done32),
      .result(res32), .result_hi(hi32), .zero(z32), .sign(sg32),
      .overflow(ov32), .div_by_zero(dz32)
   );

   alu_seq #(.WIDTH(8)) u_dut8 (
      .clk(clk), .reset(reset), .start(s8), .ALUopcode(op8),
      .rega(a8), .regb(b8), .busy(busy8), .done(done8),
      .result(res8), .result_hi(hi8), .zero(z8), .sign(sg8),
      .overflow(ov8), .div_by_zero(dz8)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic cur_done(input bit w8);
      return w8 ? done8 : done32;
   endfunction

   function automatic logic cur_busy(input bit w8);
      return w8 ? busy8 : busy32;
   endfunction

   // Issue one operation, wait for done (bounded), then check everything.
   task automatic tv(input string tag, input bit w8, input logic [3:0] op,
                     input logic [31:0] a, input logic [31:0] b, input bit pulse,
                     input logic [63:0] er, input logic [63:0] eh,
                     input bit ez, input bit es, input bit eo, input bit ed,
                     input int el, input int eb);
      int lat;
      int bcnt;
      logic [63:0] g_res, g_hi;
      logic g_z, g_s, g_o, g_d;
      @(negedge clk);
      if (w8) begin
         s8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
      end else begin
         s32 = 1'b1; op32 = op; a32 = a; b32 = b;
      end
      @(posedge clk);
      lat  = 1;
      bcnt = 0;
      @(negedge clk);
      s8 = 1'b0; s32 = 1'b0;
      while (!cur_done(w8) && lat < 100) begin
         if (cur_busy(w8)) bcnt++;
         // ADD request with fresh operands while busy: must be ignored
         if (pulse && !w8 && lat == 10) begin
            s32 = 1'b1; op32 = OP_ADD; a32 = 32'd1; b32 = 32'd1;
         end
         @(posedge clk);
         lat++;
         @(negedge clk);
         s8 = 1'b0; s32 = 1'b0;
      end
      check({tag, ".done"}, {63'd0, cur_done(w8)}, 64'd1);
      if (w8) begin
         g_res = {56'd0, res8}; g_hi = {56'd0, hi8};
         g_z = z8; g_s = sg8; g_o = ov8; g_d = dz8;
      end else begin
         g_res = {32'd0, res32}; g_hi = {32'd0, hi32};
         g_z = z32; g_s = sg32; g_o = ov32; g_d = dz32;
      end
      check({tag, ".result"}, g_res, er);
      check({tag, ".result_hi"}, g_hi, eh);
      check({tag, ".zero"}, {63'd0, g_z}, {63'd0, ez});
      check({tag, ".sign"}, {63'd0, g_s}, {63'd0, es});
      check({tag, ".overflow"}, {63'd0, g_o}, {63'd0, eo});
      check({tag, ".div_by_zero"}, {63'd0, g_d}, {63'd0, ed});
      check({tag, ".latency"}, 64'(lat), 64'(el));
      check({tag, ".busy_cycles"}, 64'(bcnt), 64'(eb));
      check({tag, ".busy_at_done"}, {63'd0, cur_busy(w8)}, 64'd0);
      @(posedge clk);
      @(negedge clk);
      check({tag, ".done_pulse"}, {63'd0, cur_done(w8)}, 64'd0);
      $display("op %-10s w8=%0d a=%h b=%h -> res=%h hi=%h z%0d s%0d o%0d dz%0d lat=%0d busy=%0d",
               tag, w8, a, b, g_res, g_hi, g_z, g_s, g_o, g_d, lat, bcnt);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int dcnt;
      int bsy;
      reset = 1'b1;
      s32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
      s8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst.busy",   {63'd0, busy32}, 64'd0);
      check("rst.done",   {63'd0, done32}, 64'd0);
      check("rst.result", {32'd0, res32},  64'd0);
      check("rst.hi",     {32'd0, hi32},   64'd0);
      check("rst.zero",   {63'd0, z32},    64'd0);
      check("rst.flags",  {61'd0, sg32, ov32, dz32}, 64'd0);
      check("rst8.zero",  {63'd0, z8},     64'd0);
      reset = 1'b0;

      //  tag         w8 op       a             b             p  result               hi                   z  s  o  dz lat busy
      tv("add_ovf",  0, OP_ADD,  32'h7FFFFFFF, 32'h00000001, 0, 64'h80000000, 64'h0,          0, 1, 1, 0, 1, 0);
      tv("slt",      0, OP_SLT,  32'hFFFFFFFF, 32'h00000001, 0, 64'h1,        64'h0,          0, 0, 0, 0, 1, 0);
      tv("sltu",     0, OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 0, 64'h0,        64'h0,          1, 0, 0, 0, 1, 0);
      tv("sub_zero", 0, OP_SUB,  32'd5,        32'd5,        0, 64'h0,        64'h0,          1, 0, 0, 0, 1, 0);
      tv("sub_ovf",  0, OP_SUB,  32'h80000000, 32'h00000001, 0, 64'h7FFFFFFF, 64'h0,          0, 0, 1, 0, 1, 0);
      tv("sra",      0, OP_SRA,  32'h80000000, 32'd36,       0, 64'hF8000000, 64'h0,          0, 1, 0, 0, 1, 0);
      tv("srl",      0, OP_SRL,  32'h80000000, 32'd36,       0, 64'h08000000, 64'h0,          0, 0, 0, 0, 1, 0);
      tv("sll",      0, OP_SLL,  32'h00000001, 32'd31,       0, 64'h80000000, 64'h0,          0, 1, 0, 0, 1, 0);
      tv("and",      0, OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 0, 64'hF000F000, 64'h0,          0, 1, 0, 0, 1, 0);
      tv("or",       0, OP_OR,   32'hF0F0F0F0, 32'hFF00FF00, 0, 64'hFFF0FFF0, 64'h0,          0, 1, 0, 0, 1, 0);
      tv("xor",      0, OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 0, 64'h0FF00FF0, 64'h0,          0, 0, 0, 0, 1, 0);
      tv("nor",      0, OP_NOR,  32'h00000000, 32'h00000000, 0, 64'hFFFFFFFF, 64'h0,          0, 1, 0, 0, 1, 0);
      tv("undef_op", 0, 4'b1111, 32'd5,        32'd6,        0, 64'h0,        64'h0,          1, 0, 0, 0, 1, 0);
      tv("mul_max",  0, OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 64'h00000001, 64'hFFFFFFFE,   0, 0, 0, 0, 32, 31);
      tv("mul_mid",  0, OP_MULU, 32'h12345678, 32'h00000010, 0, 64'h23456780, 64'h00000001,   0, 0, 0, 0, 32, 31);
      tv("div",      0, OP_DIVU, 32'd100,      32'd7,        0, 64'd14,       64'd2,          0, 0, 0, 0, 32, 31);
      tv("div_small",0, OP_DIVU, 32'd5,        32'd9,        0, 64'd0,        64'd5,          1, 0, 0, 0, 32, 31);
      tv("div_zero", 0, OP_DIVU, 32'h1234,     32'd0,        0, 64'hFFFFFFFF, 64'h1234,       0, 1, 0, 1, 1, 0);

      // back-to-back: second start issued in the done cycle of the first
      @(negedge clk);
      s32 = 1'b1; op32 = OP_ADD; a32 = 32'd1; b32 = 32'd2;
      @(posedge clk);
      @(negedge clk);
      check("b2b.done1",   {63'd0, done32}, 64'd1);
      check("b2b.result1", {32'd0, res32},  64'd3);
      op32 = OP_SUB; a32 = 32'd10; b32 = 32'd3;
      @(posedge clk);
      @(negedge clk);
      s32 = 1'b0;
      check("b2b.done2",   {63'd0, done32}, 64'd1);
      check("b2b.result2", {32'd0, res32},  64'd7);
      @(posedge clk);
      @(negedge clk);
      check("b2b.done_end", {63'd0, done32}, 64'd0);
      $display("op b2b        add 1+2 then sub 10-3 -> res=%h", res32);

      // reset 10 cycles into a DIVU
      @(negedge clk);
      s32 = 1'b1; op32 = OP_DIVU; a32 = 32'd100; b32 = 32'd7;
      repeat (10) @(posedge clk);
      @(negedge clk);
      s32 = 1'b0;
      check("abort.busy_before", {63'd0, busy32}, 64'd1);
      reset = 1'b1;
      #1;
      check("abort.busy",   {63'd0, busy32}, 64'd0);
      check("abort.done",   {63'd0, done32}, 64'd0);
      check("abort.result", {32'd0, res32},  64'd0);
      check("abort.hi",     {32'd0, hi32},   64'd0);
      check("abort.zero",   {63'd0, z32},    64'd0);
      check("abort.flags",  {61'd0, sg32, ov32, dz32}, 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      dcnt = 0;
      bsy  = 0;
      repeat (40) begin
         @(posedge clk);
         @(negedge clk);
         if (done32) dcnt++;
         if (busy32) bsy++;
      end
      check("abort.no_done", 64'(dcnt), 64'd0);
      check("abort.no_busy", 64'(bsy),  64'd0);
      check("abort.result_held", {32'd0, res32}, 64'd0);
      $display("op abort      divu reset mid-run, done pulses seen=%0d", dcnt);
      tv("add_after",0, OP_ADD,  32'd3,        32'd4,        0, 64'd7,        64'h0,          0, 0, 0, 0, 1, 0);

      // WIDTH=8 instance
      tv("mul8",     1, OP_MULU, 32'hFF,       32'hFF,       0, 64'h01,       64'hFE,         0, 0, 0, 0, 8, 7);
      tv("div8",     1, OP_DIVU, 32'd200,      32'd9,        0, 64'd22,       64'd2,          0, 0, 0, 0, 8, 7);
      tv("add8_ovf", 1, OP_ADD,  32'h7F,       32'h01,       0, 64'h80,       64'h0,          0, 1, 1, 0, 1, 0);
      tv("sra8",     1, OP_SRA,  32'h80,       32'd10,       0, 64'hE0,       64'h0,          0, 1, 0, 0, 1, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
